// File: rtl/ahb_arb4_pkg.sv
// Shared definitions for the 4-master AHB-lite arbiter: HTRANS codes, FSM states, helpers.
// Optional master-lock support is controlled by the ARB_LOCK_EN macro (see ahb_arb4.sv).
package ahb_arb4_pkg;

    localparam int NUM_MST = 4;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        ARB_ST_PARK = 2'b00,
        ARB_ST_OWN  = 2'b01,
        ARB_ST_LOCK = 2'b10
    } arb_state_t;

    function automatic logic [NUM_MST-1:0] onehot4(input logic [1:0] idx);
        logic [NUM_MST-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/ahb_arb4_if.sv
// Arbiter bus bundle: requests and address-phase status in, mux selects out.
interface ahb_arb4_if;
    import ahb_arb4_pkg::*;

    logic [NUM_MST-1:0] req;
    logic [1:0]         htrans_sel;
    logic               hmastlock_sel;
    logic               hready;
    logic [NUM_MST-1:0] addr_sel;
    logic [NUM_MST-1:0] data_sel;
    logic [1:0]         hmaster;

    // Arbiter side.
    modport slave (
        input  req, htrans_sel, hmastlock_sel, hready,
        output addr_sel, data_sel, hmaster
    );

    // Interconnect / requester side.
    modport master (
        output req, htrans_sel, hmastlock_sel, hready,
        input  addr_sel, data_sel, hmaster
    );

endinterface

// File: rtl/ahb_arb4_rr_pick4.sv
// Combinational round-robin picker: first request after 'last', wrapping mod 4.
module rr_pick4
    import ahb_arb4_pkg::*;
(
    input  logic [NUM_MST-1:0] req,
    input  logic [1:0]         last,
    output logic [NUM_MST-1:0] win_onehot,
    output logic [1:0]         win_idx,
    output logic               any
);

    // rot[k] is the request of master (last + 1 + k) mod 4, so bit 0 has top priority.
    logic [NUM_MST-1:0] rot;
    logic [1:0]         win_off;

    generate
        for (genvar gi = 0; gi < NUM_MST; gi++) begin : g_rot
            assign rot[gi] = req[last + 2'(gi + 1)];
        end
    endgenerate

    always_comb begin
        win_off = 2'd0;
        for (int k = NUM_MST - 1; k >= 0; k--) begin
            if (rot[k]) begin
                win_off = 2'(k);
            end
        end
        any        = |rot;
        win_idx    = last + win_off + 2'd1;
        win_onehot = onehot4(win_idx);
    end

endmodule

// File: rtl/ahb_arb4.sv
// 4-master round-robin AHB-lite arbiter producing address- and data-phase mux selects.
// Define ARB_LOCK_EN to make HMASTLOCK hold the grant until the locked sequence ends.
module ahb_arb4
    import ahb_arb4_pkg::*;
#(
    parameter int unsigned PARK_MST = 0
) (
    input  logic        hclk,
    input  logic        hreset,
    ahb_arb4_if.slave   bus
);

    localparam logic [1:0] PARK_IDX = 2'(PARK_MST);

    arb_state_t         state_reg, state_next;
    logic [NUM_MST-1:0] addr_sel_reg;
    logic [NUM_MST-1:0] data_sel_reg;
    logic [1:0]         hmaster_reg;
    logic [1:0]         last_reg;

    logic [NUM_MST-1:0] win_onehot;
    logic [1:0]         win_idx;
    logic               win_any;
    logic               lock_hold;
    logic               ap;

    rr_pick4 u_pick (
        .req        (bus.req),
        .last       (last_reg),
        .win_onehot (win_onehot),
        .win_idx    (win_idx),
        .any        (win_any)
    );

`ifdef ARB_LOCK_EN
    assign lock_hold = (state_reg == ARB_ST_LOCK) || (bus.hmastlock_sel && bus.hready);
`else
    assign lock_hold = 1'b0;
`endif

    // Re-arbitrate only between transfers or once the owner has dropped its request.
    assign ap = bus.hready && !lock_hold &&
                ((bus.htrans_sel == HTRANS_IDLE) || !bus.req[hmaster_reg]);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ARB_ST_PARK: begin
                if (ap && win_any) begin
                    state_next = ARB_ST_OWN;
                end
            end
            ARB_ST_OWN: begin
`ifdef ARB_LOCK_EN
                if (bus.hready && bus.hmastlock_sel) begin
                    state_next = ARB_ST_LOCK;
                end else
`endif
                if (ap && !win_any) begin
                    state_next = ARB_ST_PARK;
                end
            end
            ARB_ST_LOCK: begin
                if (bus.hready && !bus.hmastlock_sel) begin
                    state_next = bus.req[hmaster_reg] ? ARB_ST_OWN : ARB_ST_PARK;
                end
            end
            default: state_next = ARB_ST_PARK;
        endcase
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_reg    <= ARB_ST_PARK;
            addr_sel_reg <= onehot4(PARK_IDX);
            hmaster_reg  <= PARK_IDX;
            last_reg     <= PARK_IDX - 2'd1;
            data_sel_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (ap && win_any) begin
                addr_sel_reg <= win_onehot;
                hmaster_reg  <= win_idx;
                last_reg     <= win_idx;
            end
            // NONSEQ/SEQ (htrans[1]=1) open a data phase for the current address owner.
            if (bus.hready) begin
                data_sel_reg <= addr_sel_reg & {NUM_MST{bus.htrans_sel[1]}};
            end
        end
    end

    assign bus.addr_sel = addr_sel_reg;
    assign bus.data_sel = data_sel_reg;
    assign bus.hmaster  = hmaster_reg;

endmodule

// File: tb/tb_ahb_arb4.sv
// Scoreboard bench for ahb_arb4: directed per-cycle vectors, expectations queued and checked by a monitor.
module tb_ahb_arb4;
    import ahb_arb4_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ahb_arb4_if bus ();

    ahb_arb4 #(.PARK_MST(0)) dut (
        .hclk   (clk),
        .hreset (rst),
        .bus    (bus)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] d;
        string      nm;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    exp_t mon_e;

    function automatic logic [1:0] idx_of(input logic [3:0] oh);
        case (oh)
            4'b0001: return 2'd0;
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    // Monitor: every cycle with a pending expectation, compare the post-edge outputs.
    always @(posedge clk) begin
        #1;
        if (q.size() != 0) begin
            mon_e = q.pop_front();
            checks++;
            if (bus.addr_sel !== mon_e.a) begin
                errors++;
                $display("FAIL %s addr_sel got %b want %b", mon_e.nm, bus.addr_sel, mon_e.a);
            end
            checks++;
            if (bus.data_sel !== mon_e.d) begin
                errors++;
                $display("FAIL %s data_sel got %b want %b", mon_e.nm, bus.data_sel, mon_e.d);
            end
            checks++;
            if (bus.hmaster !== idx_of(mon_e.a)) begin
                errors++;
                $display("FAIL %s hmaster got %0d want %0d", mon_e.nm, bus.hmaster, idx_of(mon_e.a));
            end
            $display("cycle %-14s req=%b htrans=%b lock=%b hready=%b rst=%b -> addr_sel=%b data_sel=%b hmaster=%0d",
                     mon_e.nm, bus.req, bus.htrans_sel, bus.hmastlock_sel, bus.hready, rst,
                     bus.addr_sel, bus.data_sel, bus.hmaster);
        end
    end

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic cyc(input logic [3:0] r, input logic [1:0] t, input logic l,
                       input logic hr, input logic rs,
                       input logic [3:0] ea, input logic [3:0] ed, input string nm);
        exp_t e;
        @(negedge clk);
        bus.req           = r;
        bus.htrans_sel    = t;
        bus.hmastlock_sel = l;
        bus.hready        = hr;
        rst               = rs;
        e.a  = ea;
        e.d  = ed;
        e.nm = nm;
        q.push_back(e);
    endtask

    initial begin
        bus.req           = 4'b0000;
        bus.htrans_sel    = HTRANS_IDLE;
        bus.hmastlock_sel = 1'b0;
        bus.hready        = 1'b1;

        // Reset held two cycles
        cyc(4'b0000, HTRANS_IDLE, 0, 1, 1, 4'b0001, 4'b0000, "rst0");
        cyc(4'b0000, HTRANS_IDLE, 0, 1, 1, 4'b0001, 4'b0000, "rst1");

        // All four requesting, IDLE: strict rotation from master 0
        cyc(4'b1111, HTRANS_IDLE, 0, 1, 0, 4'b0001, 4'b0000, "rr0");
        cyc(4'b1111, HTRANS_IDLE, 0, 1, 0, 4'b0010, 4'b0000, "rr1");
        cyc(4'b1111, HTRANS_IDLE, 0, 1, 0, 4'b0100, 4'b0000, "rr2");
        cyc(4'b1111, HTRANS_IDLE, 0, 1, 0, 4'b1000, 4'b0000, "rr3");
        cyc(4'b1111, HTRANS_IDLE, 0, 1, 0, 4'b0001, 4'b0000, "rr4");

        // Master 1 burst with master 2 waiting; hand-over on last beat
        cyc(4'b0010, HTRANS_IDLE,   0, 1, 0, 4'b0010, 4'b0000, "b_grant1");
        cyc(4'b0110, HTRANS_NONSEQ, 0, 1, 0, 4'b0010, 4'b0010, "b_nonseq");
        cyc(4'b0110, HTRANS_SEQ,    0, 1, 0, 4'b0010, 4'b0010, "b_seq1");
        cyc(4'b0110, HTRANS_SEQ,    0, 1, 0, 4'b0010, 4'b0010, "b_seq2");
        cyc(4'b0100, HTRANS_SEQ,    0, 1, 0, 4'b0100, 4'b0010, "b_last");
        cyc(4'b0100, HTRANS_NONSEQ, 0, 1, 0, 4'b0100, 4'b0100, "b_m2_nonseq");

        // Wait states at an arbitration point freeze everything
        cyc(4'b1000, HTRANS_IDLE, 0, 0, 0, 4'b0100, 4'b0100, "ws0");
        cyc(4'b1000, HTRANS_IDLE, 0, 0, 0, 4'b0100, 4'b0100, "ws1");
        cyc(4'b1000, HTRANS_IDLE, 0, 0, 0, 4'b0100, 4'b0100, "ws2");
        cyc(4'b1000, HTRANS_IDLE, 0, 1, 0, 4'b1000, 4'b0000, "ws_release");

        // Locked owner (master 3) with master 2 requesting
`ifdef ARB_LOCK_EN
        cyc(4'b0100, HTRANS_IDLE, 1, 1, 0, 4'b1000, 4'b0000, "lock0");
        cyc(4'b0100, HTRANS_IDLE, 1, 1, 0, 4'b1000, 4'b0000, "lock1");
        cyc(4'b0100, HTRANS_IDLE, 0, 1, 0, 4'b1000, 4'b0000, "lock_drop");
        cyc(4'b0100, HTRANS_IDLE, 0, 1, 0, 4'b0100, 4'b0000, "lock_switch");
`else
        cyc(4'b0100, HTRANS_IDLE, 1, 1, 0, 4'b0100, 4'b0000, "lock0");
        cyc(4'b0100, HTRANS_IDLE, 1, 1, 0, 4'b0100, 4'b0000, "lock1");
        cyc(4'b0100, HTRANS_IDLE, 0, 1, 0, 4'b0100, 4'b0000, "lock_drop");
        cyc(4'b0100, HTRANS_IDLE, 0, 1, 0, 4'b0100, 4'b0000, "lock_switch");
`endif

        // Reset in the middle of master 1's burst
        cyc(4'b0010, HTRANS_IDLE,   0, 1, 0, 4'b0010, 4'b0000, "mr_grant1");
        cyc(4'b0010, HTRANS_NONSEQ, 0, 1, 0, 4'b0010, 4'b0010, "mr_nonseq");
        cyc(4'b0010, HTRANS_SEQ,    0, 1, 1, 4'b0001, 4'b0000, "mr_reset");
        cyc(4'b0000, HTRANS_IDLE,   0, 1, 0, 4'b0001, 4'b0000, "mr_park");
        cyc(4'b1010, HTRANS_IDLE,   0, 1, 0, 4'b0010, 4'b0000, "mr_ptr");

        // BUSY holds grant but opens no data phase
        cyc(4'b0010, HTRANS_BUSY,   0, 1, 0, 4'b0010, 4'b0000, "busy");
        cyc(4'b0010, HTRANS_NONSEQ, 0, 1, 0, 4'b0010, 4'b0010, "busy_nonseq");

        for (int i = 0; i < 10 && q.size() != 0; i++) begin
            @(posedge clk);
            #2;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d want 0", q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
